// File: rtl/mdu_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
package mdu_pkg;

   localparam int MDU_ITERS = 32;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } mdop_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ITER = 1'b1
   } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring shift-subtract
// step per enable, with sign correction applied to the final step's result.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_ITERS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] raw_a_q, raw_a_d;
   logic             div_q, div_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dz_q, dz_d;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     sum, addend, shifted, diff;
   logic [WIDTH-1:0]   step_acc, step_mq;
   logic [2*WIDTH-1:0] prod, prod_fix;

   always_comb begin
      mag_a = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
      mag_b = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;

      sum     = {1'b0, acc_q} + {1'b0, opnd_q};
      addend  = mq_q[0] ? sum : {1'b0, acc_q};
      shifted = {acc_q, mq_q[WIDTH-1]};
      diff    = shifted - {1'b0, opnd_q};

      if (div_q) begin
         // Borrow out of the subtract means the divisor did not fit: restore.
         if (!diff[WIDTH]) begin
            step_acc = diff[WIDTH-1:0];
            step_mq  = {mq_q[WIDTH-2:0], 1'b1};
         end else begin
            step_acc = shifted[WIDTH-1:0];
            step_mq  = {mq_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_acc = addend[WIDTH:1];
         step_mq  = {addend[0], mq_q[WIDTH-1:1]};
      end

      prod     = {step_acc, step_mq};
      prod_fix = neg_res_q ? -prod : prod;

      if (!div_q) begin
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
         res_lo = prod_fix[WIDTH-1:0];
      end else if (dz_q) begin
         res_hi = raw_a_q;
         res_lo = '1;
      end else begin
         res_hi = neg_rem_q ? -step_acc : step_acc;
         res_lo = neg_res_q ? -step_mq : step_mq;
      end
   end

   always_comb begin
      acc_d     = acc_q;
      mq_d      = mq_q;
      opnd_d    = opnd_q;
      raw_a_d   = raw_a_q;
      div_d     = div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      if (load) begin
         acc_d     = '0;
         mq_d      = is_div ? mag_a : mag_b;
         opnd_d    = is_div ? mag_b : mag_a;
         raw_a_d   = src_a;
         div_d     = is_div;
         neg_res_d = is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
         neg_rem_d = is_signed & src_a[WIDTH-1];
         dz_d      = is_div & (src_b == '0);
      end else if (step) begin
         acc_d = step_acc;
         mq_d  = step_mq;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         mq_q      <= '0;
         opnd_q    <= '0;
         raw_a_q   <= '0;
         div_q     <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         opnd_q    <= opnd_d;
         raw_a_q   <= raw_a_d;
         div_q     <= div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
      end
   end

endmodule

// File: rtl/mdu_e.sv
// Execute-stage multiply/divide unit: sequencing FSM, HI/LO registers and stall.
//   state   | meaning
//   ST_IDLE | accepts MULT/DIV (to ST_ITER) and MTHI/MTLO (single cycle)
//   ST_ITER | one datapath step per cycle; HI/LO written on the last step
module mdu_e
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_ITERS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StartE,
   input  logic [2:0]       MdOpE,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   input  logic             ReadHiLoE,
   output logic [WIDTH-1:0] HiE,
   output logic [WIDTH-1:0] LoE,
   output logic             BusyE,
   output logic             StallE
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mdu_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   mdop_t            op;
   logic             load, step, is_div, is_signed;
   logic [WIDTH-1:0] res_hi, res_lo;

   always_comb begin
      op        = mdop_t'(MdOpE);
      is_div    = (op == MD_DIV) || (op == MD_DIVU);
      is_signed = (op == MD_MULT) || (op == MD_DIV);
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      load      = 1'b0;
      step      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (StartE) begin
               case (op)
                  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                     load    = 1'b1;
                     state_d = ST_ITER;
                     cnt_d   = '0;
                  end
                  MD_MTHI: hi_d = SrcAE;
                  MD_MTLO: lo_d = SrcAE;
                  default: ;
               endcase
            end
         end
         ST_ITER: begin
            step = 1'b1;
            if (cnt_q == CNT_LAST) begin
               hi_d    = res_hi;
               lo_d    = res_lo;
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   mdu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk       (clk),
      .rst_n     (reset),
      .load      (load),
      .step      (step),
      .is_div    (is_div),
      .is_signed (is_signed),
      .src_a     (SrcAE),
      .src_b     (SrcBE),
      .res_hi    (res_hi),
      .res_lo    (res_lo)
   );

   // Stall is purely combinational so a held op is released the first idle cycle.
   assign BusyE  = (state_q == ST_ITER);
   assign StallE = BusyE & (StartE | ReadHiLoE);
   assign HiE    = hi_q;
   assign LoE    = lo_q;

endmodule

// File: tb/tb_mdu_e.sv
// Self-checking bench for mdu_e: directed vector table, stall/hold sequences,
// and random ops against an arithmetic reference model.
module tb_mdu_e;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        StartE;
   logic [2:0]  MdOpE;
   logic [31:0] SrcAE, SrcBE;
   logic        ReadHiLoE;
   logic [31:0] HiE, LoE;
   logic        BusyE, StallE;

   int n_vec = 0;
   int n_bad = 0;

   mdu_e #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .StartE    (StartE),
      .MdOpE     (MdOpE),
      .SrcAE     (SrcAE),
      .SrcBE     (SrcBE),
      .ReadHiLoE (ReadHiLoE),
      .HiE       (HiE),
      .LoE       (LoE),
      .BusyE     (BusyE),
      .StallE    (StallE)
   );

   always #5 clk = ~clk;

   typedef struct {
      mdop_t       op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t tbl[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference result {hi, lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input mdop_t op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         MD_MULT:  begin p = sa * sb; return p; end
         MD_MULTU: begin p = {32'b0, a} * {32'b0, b}; return p; end
         MD_DIV: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         MD_DIVU: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
         default: return 64'h0;
      endcase
   endfunction

   task automatic run_op(input mdop_t op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cyc);
      StartE = 1'b1;
      MdOpE  = op;
      SrcAE  = a;
      SrcBE  = b;
      @(posedge clk); #1;
      StartE   = 1'b0;
      MdOpE    = MD_NONE;
      busy_cyc = 0;
      while (BusyE && busy_cyc < 100) begin
         busy_cyc++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          bc, st_cyc, bad_st;
      logic [63:0] exp;
      mdop_t       rop;
      logic [31:0] ra, rb;

      tbl[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      tbl[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      tbl[2]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      tbl[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[4]  = '{MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
      tbl[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      tbl[6]  = '{MD_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
      tbl[7]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      tbl[8]  = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF};
      tbl[9]  = '{MD_MTHI,  32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h7FFFFFFF};
      tbl[10] = '{MD_MTLO,  32'hCAFEF00D, 32'h00000000, 32'hDEADBEEF, 32'hCAFEF00D};

      // Reset held with random inputs.
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         StartE    = 1'($urandom);
         MdOpE     = 3'($urandom_range(0, 6));
         SrcAE     = $urandom;
         SrcBE     = $urandom;
         ReadHiLoE = 1'($urandom);
         @(posedge clk); #1;
         check("rst_hi", HiE, 32'h0);
         check("rst_lo", LoE, 32'h0);
         check("rst_busy", {31'b0, BusyE}, 32'h0);
         check("rst_stall", {31'b0, StallE}, 32'h0);
      end
      StartE = 1'b0;
      MdOpE  = MD_NONE;
      reset  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         SrcAE     = $urandom;
         SrcBE     = $urandom;
         ReadHiLoE = 1'($urandom);
         @(posedge clk); #1;
         check("post_rst_hilo", HiE | LoE, 32'h0);
         check("post_rst_busy_stall", {30'b0, BusyE, StallE}, 32'h0);
      end
      ReadHiLoE = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, bc);
         check($sformatf("tbl%0d_busy", i), bc,
               (tbl[i].op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) ? 32 : 0);
         check($sformatf("tbl%0d_hi", i), HiE, tbl[i].hi);
         check($sformatf("tbl%0d_lo", i), LoE, tbl[i].lo);
      end

      // MFHI/MFLO during DIVU stalls through the final iteration only.
      StartE = 1'b1; MdOpE = MD_DIVU; SrcAE = 32'd100; SrcBE = 32'd7;
      @(posedge clk); #1;
      StartE = 1'b0; MdOpE = MD_NONE; ReadHiLoE = 1'b1;
      st_cyc = 0; bad_st = 0;
      while (BusyE && st_cyc < 100) begin
         if (StallE) st_cyc++; else bad_st++;
         @(posedge clk); #1;
      end
      check("rd_stall_cycles", st_cyc, 32);
      check("rd_stall_gaps", bad_st, 0);
      check("rd_stall_after", {31'b0, StallE}, 32'h0);
      check("divu_hi", HiE, 32'd2);
      check("divu_lo", LoE, 32'd14);
      ReadHiLoE = 1'b0;

      // MTLO held across a DIVU is accepted once idle and overrides LO.
      StartE = 1'b1; MdOpE = MD_DIVU; SrcAE = 32'd100; SrcBE = 32'd7;
      @(posedge clk); #1;
      MdOpE = MD_MTLO; SrcAE = 32'h1234;
      st_cyc = 0;
      while (BusyE && st_cyc < 100) begin
         if (StallE) st_cyc++;
         @(posedge clk); #1;
      end
      check("mtlo_stall_cycles", st_cyc, 32);
      check("mtlo_pre_lo", LoE, 32'd14);
      check("mtlo_pre_stall", {31'b0, StallE}, 32'h0);
      @(posedge clk); #1;
      StartE = 1'b0; MdOpE = MD_NONE;
      check("mtlo_lo", LoE, 32'h1234);
      check("mtlo_hi", HiE, 32'd2);
      check("mtlo_busy", {31'b0, BusyE}, 32'h0);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       rop = MD_MULT;
            1:       rop = MD_MULTU;
            2:       rop = MD_DIV;
            default: rop = MD_DIVU;
         endcase
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'h0;
            1, 2:    rb = 32'($urandom_range(1, 20));
            3:       rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         exp = model(rop, ra, rb);
         run_op(rop, ra, rb, bc);
         check($sformatf("rnd%0d_busy", i), bc, 32);
         check($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, rop, ra, rb), HiE, exp[63:32]);
         check($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, rop, ra, rb), LoE, exp[31:0]);
      end

      // Reset mid-iteration discards the op and clears HI/LO at once.
      run_op(MD_MTHI, 32'h5A5A5A5A, 32'h0, bc);
      StartE = 1'b1; MdOpE = MD_MULT; SrcAE = 32'd12345; SrcBE = 32'hFFFFFD5A;
      @(posedge clk); #1;
      StartE = 1'b0; MdOpE = MD_NONE;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_busy", {31'b0, BusyE}, 32'h0);
      check("midrst_hi", HiE, 32'h0);
      check("midrst_lo", LoE, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      run_op(MD_MULTU, 32'd5, 32'd6, bc);
      check("after_rst_busy", bc, 32);
      check("after_rst_hi", HiE, 32'd0);
      check("after_rst_lo", LoE, 32'd30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
